row_feeder: RTL and testbench

Collects the serial 8-bit pixel stream of one sensor line into a 120-pixel row and presents it as a single wide word to the downstream convolution/peak-finding stage (convmax). It is the producer side of the row interface that convmax consumes. A double buffer lets the next line fill while the previous row waits for the consumer. Lines arriving while both buffers are occupied are dropped and flagged.

---
 rtl/plazer_pkg.sv | 18 +
 rtl/row_slot.sv | 53 +++++
 rtl/row_feeder.sv | 179 +++++++++++++++++
 tb/tb_row_feeder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plazer_pkg.sv
// Shared types and default geometry for the sensor-line to row interface.
package plazer_pkg;

  localparam int unsigned NPIX = 120;
  localparam int unsigned PW   = 8;
  localparam int unsigned IDXW = 10;

  typedef logic [PW-1:0]    pixel_t;
  typedef pixel_t [NPIX-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    SKIP
  } fill_state_t;

endpackage

// File: rtl/row_slot.sv
// Output row register with valid/ready handshake toward the consumer.
// free is high when the slot is empty or is being emptied this cycle, so the
// producer may load on the same edge that the consumer takes the old row.
module row_slot
  import plazer_pkg::*;
#(
  parameter int unsigned NPIX = plazer_pkg::NPIX,
  parameter int unsigned PW   = plazer_pkg::PW,
  parameter int unsigned IDXW = plazer_pkg::IDXW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NPIX-1:0][PW-1:0]  load_data,
  input  logic [IDXW-1:0]          load_index,
  input  logic                     ready,
  output logic [NPIX-1:0][PW-1:0]  row_data,
  output logic [IDXW-1:0]          row_index,
  output logic                     row_valid,
  output logic                     free
);

  logic [NPIX-1:0][PW-1:0] r_data;
  logic [IDXW-1:0]         r_index;
  logic                    r_valid;

  assign free      = ~r_valid | ready;
  assign row_data  = r_data;
  assign row_index = r_index;
  assign row_valid = r_valid;

  // Slot register: load wins over drain so a handoff keeps row_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_index <= load_index;
      r_valid <= 1'b1;
    end else if (ready) begin
      r_valid <= 1'b0;
    end
  end

  a_load_when_free : assert property (@(posedge clk) disable iff (reset)
    load |-> free);

  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
    (r_valid && !ready) |=> (r_valid && $stable(r_data) && $stable(r_index)));

endmodule

// File: rtl/row_feeder.sv
// Assembles the serial pixel stream of one sensor line into a full row and
// hands it to the output slot. The fill buffer plus the output slot form a
// double buffer; line starts that find both occupied are dropped and flagged.
module row_feeder
  import plazer_pkg::*;
#(
  parameter int unsigned NPIX = plazer_pkg::NPIX,
  parameter int unsigned PW   = plazer_pkg::PW,
  parameter int unsigned IDXW = plazer_pkg::IDXW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PW-1:0]            pix_data,
  input  logic                     pix_valid,
  input  logic                     pix_sol,
  output logic [NPIX-1:0][PW-1:0]  row_data,
  output logic [IDXW-1:0]          row_index,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic                     overrun,
  output logic                     short_row
);

  localparam int unsigned      CW   = $clog2(NPIX + 1);
  localparam logic [CW-1:0]    LAST = CW'(NPIX - 1);

  fill_state_t             r_state;
  fill_state_t             w_state_nxt;
  logic [NPIX-1:0][PW-1:0] r_buf;
  logic [NPIX-1:0][PW-1:0] w_buf_nxt;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_nxt;
  logic [IDXW-1:0]         r_line_cnt;
  logic [IDXW-1:0]         r_cur_idx;
  logic                    r_overrun;
  logic                    r_short_row;

  logic                    w_sol;
  logic                    w_last;
  logic                    w_free;
  logic                    w_wr_en;
  logic [CW-1:0]           w_wr_addr;
  logic                    w_capture;
  logic                    w_load;
  logic                    w_overrun;
  logic                    w_short;

  assign w_sol  = pix_valid & pix_sol;
  assign w_last = pix_valid & ~pix_sol & (r_count == LAST);

  assign overrun   = r_overrun;
  assign short_row = r_short_row;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the fill FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, SKIP: begin
        if (w_sol) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (w_sol) begin
          w_state_nxt = FILL;
        end else if (w_last) begin
          w_state_nxt = w_free ? SKIP : HOLD;
        end
      end
      HOLD: begin
        if (w_free) begin
          w_state_nxt = SKIP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: buffer writes, index capture, slot load and flag requests.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_count_nxt = r_count;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      IDLE, SKIP: begin
        if (w_sol) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = '0;
          w_count_nxt = CW'(1);
          w_capture   = 1'b1;
        end
      end
      FILL: begin
        if (w_sol) begin
          w_short     = 1'b1;
          w_wr_en     = 1'b1;
          w_wr_addr   = '0;
          w_count_nxt = CW'(1);
          w_capture   = 1'b1;
        end else if (pix_valid) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = r_count;
          w_count_nxt = r_count + CW'(1);
          w_load      = w_last & w_free;
        end
      end
      HOLD: begin
        w_overrun = w_sol;
        w_load    = w_free;
      end
      default: ;
    endcase
  end

  // Fill buffer with the current pixel merged in; the completing pixel goes
  // straight to the slot through this path so the row appears one cycle later.
  always_comb begin
    w_buf_nxt = r_buf;
    for (int unsigned i = 0; i < NPIX; i++) begin
      if (w_wr_en && (w_wr_addr == CW'(i))) begin
        w_buf_nxt[i] = pix_data;
      end
    end
  end

  // Fill datapath: buffer, pixel count, line counter and one-cycle flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf       <= '0;
      r_count     <= '0;
      r_line_cnt  <= '0;
      r_cur_idx   <= '0;
      r_overrun   <= 1'b0;
      r_short_row <= 1'b0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_count     <= w_count_nxt;
      r_overrun   <= w_overrun;
      r_short_row <= w_short;
      if (w_sol) begin
        r_line_cnt <= r_line_cnt + IDXW'(1);
      end
      if (w_capture) begin
        r_cur_idx <= r_line_cnt;
      end
    end
  end

  row_slot #(
    .NPIX (NPIX),
    .PW   (PW),
    .IDXW (IDXW)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_data  (w_buf_nxt),
    .load_index (r_cur_idx),
    .ready      (row_ready),
    .row_data   (row_data),
    .row_index  (row_index),
    .row_valid  (row_valid),
    .free       (w_free)
  );

endmodule

// File: tb/tb_row_feeder.sv
// Scoreboard bench for row_feeder: expected rows are queued as lines are
// driven and compared with the rows the consumer side accepts.
module tb_row_feeder;
  import plazer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_sol;
  row_t       row_data;
  logic [9:0] row_index;
  logic       row_valid;
  logic       row_ready;
  logic       overrun;
  logic       short_row;

  logic [7:0]      s_pix;
  logic            s_valid;
  logic            s_sol;
  logic            s_ready;
  logic [7:0][7:0] s_row_data;
  logic [9:0]      s_row_index;
  logic            s_row_valid;
  logic            s_overrun;
  logic            s_short_row;

  typedef struct {
    logic [9:0] idx;
    row_t       data;
    longint     cyc;
  } row_rec_t;

  row_rec_t sb_exp[$];
  row_rec_t obs[$];

  int     checks = 0;
  int     errors = 0;
  int     tb_line = 0;
  int     n_ovr = 0;
  int     n_short = 0;
  longint cyc = 0;
  int     s_rows = 0;
  int     s_seq_bad = 0;
  int     s_flags = 0;
  logic [9:0] s_last_idx;

  always #5 clk = ~clk;

  row_feeder #(
    .NPIX (120),
    .PW   (8),
    .IDXW (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_sol   (pix_sol),
    .row_data  (row_data),
    .row_index (row_index),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .overrun   (overrun),
    .short_row (short_row)
  );

  row_feeder #(
    .NPIX (8),
    .PW   (8),
    .IDXW (10)
  ) u_small (
    .clk       (clk),
    .reset     (reset),
    .pix_data  (s_pix),
    .pix_valid (s_valid),
    .pix_sol   (s_sol),
    .row_data  (s_row_data),
    .row_index (s_row_index),
    .row_valid (s_row_valid),
    .row_ready (s_ready),
    .overrun   (s_overrun),
    .short_row (s_short_row)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted rows and flag pulses of the main instance.
  always @(negedge clk) begin : mon
    row_rec_t r;
    if (!reset) begin
      if (row_valid && row_ready) begin
        r.idx  = row_index;
        r.data = row_data;
        r.cyc  = cyc;
        obs.push_back(r);
      end
      if (overrun)   n_ovr++;
      if (short_row) n_short++;
    end
  end

  // Track the small instance's row sequence: index and content follow line number.
  always @(negedge clk) begin
    if (!reset) begin
      if (s_row_valid && s_ready) begin
        if (s_row_index !== s_rows[9:0]) s_seq_bad++;
        if (s_row_data[0] !== s_rows[7:0] || s_row_data[7] !== s_rows[7:0]) s_seq_bad++;
        s_last_idx = s_row_index;
        s_rows++;
      end
      if (s_overrun || s_short_row) s_flags++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    pix_data  = '0;
    s_valid   = 1'b0;
    s_sol     = 1'b0;
    s_pix     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tb_line = 0;
    sb_exp.delete();
    obs.delete();
    n_ovr = 0;
    n_short = 0;
  endtask

  task automatic drive_pix(input logic [7:0] d, input bit sol);
    pix_data  = d;
    pix_valid = 1'b1;
    pix_sol   = sol;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
  endtask

  // Drive one line of n pixels (sol on the first); queue the expected row if complete.
  task automatic send_line(input int n, input int base, input bit push);
    row_rec_t e;
    e.idx  = tb_line[9:0];
    e.data = '0;
    e.cyc  = 0;
    tb_line++;
    for (int i = 0; i < n; i++) begin
      if (i < 120) e.data[i] = 8'(base + i);
      drive_pix(8'(base + i), i == 0);
    end
    if (push && n >= 120) sb_exp.push_back(e);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    pix_data  = '0;
    row_ready = 1'b1;
    s_valid   = 1'b0;
    s_sol     = 1'b0;
    s_pix     = '0;
    s_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", row_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
    checks++; if (short_row !== 1'b0) begin errors++; $display("FAIL rst_short: got %b, expected 0", short_row); end
    checks++; if (row_index !== 10'd0) begin errors++; $display("FAIL rst_index: got %0d, expected 0", row_index); end
    checks++; if (row_data !== '0) begin errors++; $display("FAIL rst_data: got low %h, expected 0", row_data[7:0]); end
    reset = 1'b0;
  endtask

  task automatic test_one_line();
    row_rec_t o, e;
    do_reset();
    row_ready = 1'b1;
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL one_pre_valid: got %b, expected 0", row_valid); end
    send_line(120, 0, 1);
    #3;
    checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL one_latency: row_valid got %b, expected 1 one cycle after last pixel", row_valid); end
    @(posedge clk); #4;
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL one_single_cycle: row_valid got %b, expected 0", row_valid); end
    repeat (3) @(negedge clk);
    checks++; if (obs.size() !== sb_exp.size()) begin errors++; $display("FAIL one_row_count: got %0d rows, expected %0d", obs.size(), sb_exp.size()); end
    while (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL one_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin
        int p; p = 0;
        while (p < 119 && o.data[p] === e.data[p]) p++;
        errors++; $display("FAIL one_data: pixel %0d got %h, expected %h", p, o.data[p], e.data[p]);
      end
    end
    checks++; if (n_ovr !== 0 || n_short !== 0) begin errors++; $display("FAIL one_flags: got overrun %0d short %0d, expected 0 0", n_ovr, n_short); end
  endtask

  task automatic test_backpressure();
    row_rec_t o, e;
    longint c0;
    do_reset();
    row_ready = 1'b0;
    send_line(120, 0, 1);
    send_line(120, 8'h40, 1);
    send_line(10, 8'h80, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (n_ovr !== 1) begin errors++; $display("FAIL bp_overrun: got %0d pulse cycles, expected 1", n_ovr); end
    checks++; if (row_valid !== 1'b1 || row_index !== 10'd0) begin errors++; $display("FAIL bp_held: got valid %b index %0d, expected 1 0", row_valid, row_index); end
    checks++; if (row_data[5] !== 8'd5 || row_data[119] !== 8'd119) begin errors++; $display("FAIL bp_stable: got %h %h, expected 05 77", row_data[5], row_data[119]); end
    checks++; if (obs.size() !== 0) begin errors++; $display("FAIL bp_no_accept: got %0d rows, expected 0", obs.size()); end
    row_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (obs.size() !== sb_exp.size()) begin errors++; $display("FAIL bp_row_count: got %0d rows, expected %0d", obs.size(), sb_exp.size()); end
    c0 = (obs.size() > 0) ? obs[0].cyc : 0;
    checks++; if (obs.size() < 2 || obs[1].cyc !== c0 + 1) begin errors++; $display("FAIL bp_release: second row %0d rows seen, expected on the next cycle", obs.size()); end
    while (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL bp_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin
        int p; p = 0;
        while (p < 119 && o.data[p] === e.data[p]) p++;
        errors++; $display("FAIL bp_data: pixel %0d got %h, expected %h", p, o.data[p], e.data[p]);
      end
    end
    send_line(120, 8'h20, 1);
    repeat (3) @(negedge clk);
    checks++; if (obs.size() !== 1 || sb_exp.size() !== 1) begin errors++; $display("FAIL bp_next_count: got %0d rows, expected 1", obs.size()); end
    if (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL bp_next_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin errors++; $display("FAIL bp_next_data: pixel 0 got %h, expected %h", o.data[0], e.data[0]); end
    end
    sb_exp.delete();
  endtask

  task automatic test_short_line();
    row_rec_t o, e;
    do_reset();
    row_ready = 1'b1;
    send_line(50, 8'h10, 0);
    send_line(120, 8'h30, 1);
    repeat (3) @(negedge clk);
    checks++; if (n_short !== 1) begin errors++; $display("FAIL short_pulse: got %0d pulse cycles, expected 1", n_short); end
    checks++; if (n_ovr !== 0) begin errors++; $display("FAIL short_overrun: got %0d, expected 0", n_ovr); end
    checks++; if (obs.size() !== sb_exp.size()) begin errors++; $display("FAIL short_row_count: got %0d rows, expected %0d", obs.size(), sb_exp.size()); end
    while (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL short_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin
        int p; p = 0;
        while (p < 119 && o.data[p] === e.data[p]) p++;
        errors++; $display("FAIL short_data: pixel %0d got %h, expected %h", p, o.data[p], e.data[p]);
      end
    end
  endtask

  task automatic test_long_line();
    row_rec_t o, e;
    do_reset();
    row_ready = 1'b1;
    send_line(130, 0, 1);
    repeat (3) @(negedge clk);
    checks++; if (n_short !== 0 || n_ovr !== 0) begin errors++; $display("FAIL long_flags: got short %0d overrun %0d, expected 0 0", n_short, n_ovr); end
    checks++; if (obs.size() !== sb_exp.size()) begin errors++; $display("FAIL long_row_count: got %0d rows, expected %0d", obs.size(), sb_exp.size()); end
    while (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL long_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin
        int p; p = 0;
        while (p < 119 && o.data[p] === e.data[p]) p++;
        errors++; $display("FAIL long_data: pixel %0d got %h, expected %h", p, o.data[p], e.data[p]);
      end
    end
  endtask

  task automatic test_reset_midline();
    row_rec_t o, e;
    do_reset();
    row_ready = 1'b1;
    send_line(60, 8'h55, 0);
    do_reset();
    send_line(120, 8'h11, 1);
    repeat (3) @(negedge clk);
    checks++; if (obs.size() !== sb_exp.size()) begin errors++; $display("FAIL midrst_row_count: got %0d rows, expected %0d", obs.size(), sb_exp.size()); end
    while (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL midrst_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin
        int p; p = 0;
        while (p < 119 && o.data[p] === e.data[p]) p++;
        errors++; $display("FAIL midrst_data: pixel %0d got %h, expected %h", p, o.data[p], e.data[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_rec_t o, e;
    do_reset();
    row_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_line(120, 7 * k, 1);
    repeat (3) @(negedge clk);
    checks++; if (obs.size() !== sb_exp.size()) begin errors++; $display("FAIL b2b_row_count: got %0d rows, expected %0d", obs.size(), sb_exp.size()); end
    for (int k = 1; k < obs.size(); k++) begin
      checks++; if (obs[k].cyc - obs[k-1].cyc !== 120) begin errors++; $display("FAIL b2b_spacing: row %0d gap got %0d cycles, expected 120", k, obs[k].cyc - obs[k-1].cyc); end
    end
    while (obs.size() > 0 && sb_exp.size() > 0) begin
      o = obs.pop_front(); e = sb_exp.pop_front();
      checks++; if (o.idx !== e.idx) begin errors++; $display("FAIL b2b_index: got %0d, expected %0d", o.idx, e.idx); end
      checks++; if (o.data !== e.data) begin
        int p; p = 0;
        while (p < 119 && o.data[p] === e.data[p]) p++;
        errors++; $display("FAIL b2b_data: pixel %0d got %h, expected %h", p, o.data[p], e.data[p]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    s_ready   = 1'b1;
    s_rows    = 0;
    s_seq_bad = 0;
    s_flags   = 0;
    for (int line = 0; line < 1025; line++) begin
      for (int p = 0; p < 8; p++) begin
        s_pix   = 8'(line);
        s_valid = 1'b1;
        s_sol   = (p == 0);
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    s_sol   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_rows !== 1025) begin errors++; $display("FAIL wrap_row_count: got %0d rows, expected 1025", s_rows); end
    checks++; if (s_last_idx !== 10'd0) begin errors++; $display("FAIL wrap_last_index: got %0d, expected 0", s_last_idx); end
    checks++; if (s_seq_bad !== 0) begin errors++; $display("FAIL wrap_sequence: got %0d bad rows, expected 0", s_seq_bad); end
    checks++; if (s_flags !== 0) begin errors++; $display("FAIL wrap_flags: got %0d flag cycles, expected 0", s_flags); end
  endtask

  initial begin
    test_reset();
    test_one_line();
    test_backpressure();
    test_short_line();
    test_long_line();
    test_reset_midline();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
